// File: rtl/arf_elastic_buffer.sv
// Purpose: req/ack elastic FIFO between an arf output port and its consumer.
// Latency: 1 clk from the upstream capture edge to dn_ack (no bypass path).
// Backpressure: up_req drops early enough to reserve a slot for a late ack;
//               an ack into a full buffer is dropped and flagged.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   up_req        registered request to the upstream producer
//   up_ack/up_din upstream ack pulse with its data word in the same cycle
//   dn_req        request from the downstream consumer
//   dn_ack        one-cycle registered ack to the consumer, never back-to-back
//   dn_dout       data for the consumer, valid with dn_ack, held otherwise
//   level         current occupancy; empty/full decoded from it
//   err_overflow  sticky flag: an upstream word arrived with no free slot
module arf_elastic_buffer #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int level_width = $clog2(depth + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   up_req,
    input  logic                   up_ack,
    input  logic [data_width-1:0]  up_din,
    input  logic                   dn_req,
    output logic                   dn_ack,
    output logic [data_width-1:0]  dn_dout,
    output logic [level_width-1:0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   err_overflow
);

    // A depth of 1 still needs a one-bit pointer to index the array.
    localparam int ptr_width = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [ptr_width-1:0]   last_ptr  = ptr_width'(depth - 1);
    localparam logic [level_width-1:0] depth_lvl = level_width'(depth);
    // One extra bit so level + reservation cannot wrap before the compare.
    localparam logic [level_width:0]   depth_ext = (level_width + 1)'(depth);

    logic [data_width-1:0]  mem_q [depth];
    logic [data_width-1:0]  mem_d [depth];
    logic [ptr_width-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width-1:0]   rd_ptr_q, rd_ptr_d;
    logic [level_width-1:0] level_q, level_d;
    logic                   up_req_q, up_req_d;
    logic                   dn_ack_q, dn_ack_d;
    logic [data_width-1:0]  dn_dout_q, dn_dout_d;
    logic                   err_overflow_q, err_overflow_d;

    logic                   full_int;
    logic                   pop;
    logic                   overflow;
    logic                   wr_en;
    logic [level_width:0]   level_resv;

    assign full_int = (level_q == depth_lvl);

    // Pop only from stored words; dn_ack low in the previous cycle keeps
    // acks at most every other cycle.
    assign pop = dn_req && !dn_ack_q && (level_q != '0);

    // When full, a simultaneous pop frees the slot the incoming word needs:
    // wr_ptr equals rd_ptr, and the read below sees the old contents.
    assign overflow = up_ack && full_int && !pop;
    assign wr_en    = up_ack && !overflow;

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        dn_ack_d       = 1'b0;
        dn_dout_d      = dn_dout_q;
        err_overflow_d = err_overflow_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = up_din;
            wr_ptr_d        = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_width'(1);
        end

        if (pop) begin
            dn_ack_d  = 1'b1;
            dn_dout_d = mem_q[rd_ptr_q];
            rd_ptr_d  = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_width'(1);
        end

        if (overflow) begin
            err_overflow_d = 1'b1;
        end

        level_d = level_q + level_width'(wr_en) - level_width'(pop);

        // A request that is high now may still be answered next cycle after
        // it drops, so it holds one slot in reserve.
        level_resv = {1'b0, level_d} + {{level_width{1'b0}}, up_req_q};
        up_req_d   = (level_resv < depth_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            up_req_q       <= 1'b0;
            dn_ack_q       <= 1'b0;
            dn_dout_q      <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            up_req_q       <= up_req_d;
            dn_ack_q       <= dn_ack_d;
            dn_dout_q      <= dn_dout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign up_req       = up_req_q;
    assign dn_ack       = dn_ack_q;
    assign dn_dout      = dn_dout_q;
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = full_int;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_arf_elastic_buffer.sv
module tb_arf_elastic_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_req;
    logic          up_ack = 1'b0;
    logic [DW-1:0] up_din = '0;
    logic          dn_req = 1'b0;
    logic          dn_ack;
    logic [DW-1:0] dn_dout;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          err_overflow;

    arf_elastic_buffer #(.data_width(DW), .depth(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_req       (up_req),
        .up_ack       (up_ack),
        .up_din       (up_din),
        .dn_req       (dn_req),
        .dn_ack       (dn_ack),
        .dn_dout      (dn_dout),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [DW-1:0] sb[$];
    int            rx_count     = 0;
    int            tx_count     = 0;
    int            next_word    = 0;
    int            prod_limit   = 0;
    bit            prod_en      = 0;
    bit            cons_auto    = 0;
    bit            prev_ack     = 0;
    bit            saw_dead     = 0;
    logic [DW-1:0] last_rx      = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, score any output word, then drive
    // the next cycle's inputs. Any ack pulse is always cleared after one edge.
    task automatic tick();
        logic [DW-1:0] exp;
        @(posedge clk);
        #1;
        if (dn_ack) begin
            chk("dn_ack_back_to_back", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_word", dn_dout, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                chk("dn_dout_order", dn_dout, exp);
            end
            if (dn_dout == 32'hDEAD) saw_dead = 1;
            last_rx = dn_dout;
            rx_count++;
        end
        prev_ack = dn_ack;
        if (up_ack) begin
            up_ack = 1'b0;
        end else if (prod_en && up_req && next_word < prod_limit) begin
            up_ack = 1'b1;
            up_din = DW'(next_word);
            sb.push_back(DW'(next_word));
            next_word++;
            tx_count++;
        end
        if (cons_auto) dn_req = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        prod_en   = 0;
        cons_auto = 0;
        dn_req    = 1'b0;
        up_ack    = 1'b0;
        sb.delete();
        prev_ack  = 0;
        rx_count  = 0;
        tx_count  = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // T1: reset values, then up_req rises one clock after rst falls
        do_reset();
        chk("rst_up_req", 32'(up_req), 32'd0);
        chk("rst_dn_ack", 32'(dn_ack), 32'd0);
        chk("rst_dn_dout", dn_dout, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        tick();
        chk("t1_up_req_after_rst", 32'(up_req), 32'd1);

        // T2: 5000-word stream with an always-ready consumer
        do_reset();
        next_word  = 0;
        prod_limit = 5000;
        prod_en    = 1;
        cons_auto  = 1;
        for (int i = 0; i < 30000 && rx_count < 5000; i++) tick();
        chk("t2_rx_count", 32'(rx_count), 32'd5000);
        chk("t2_err", 32'(err_overflow), 32'd0);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // T3: fill with consumer stalled, then drain
        do_reset();
        next_word  = 0;
        prod_limit = 1000;
        prod_en    = 1;
        repeat (20) tick();
        chk("t3_level", 32'(level), 32'd4);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_accepted", 32'(tx_count), 32'd4);
        chk("t3_rx_none", 32'(rx_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_up_req_low", 32'(up_req), 32'd0);
        end
        cons_auto = 1;
        for (int i = 0; i < 200 && rx_count < 8; i++) tick();
        chk("t3_drain_count", 32'(rx_count), 32'd8);
        chk("t3_err", 32'(err_overflow), 32'd0);

        // T4: push and pop on the same edge at level 2
        do_reset();
        up_ack = 1'b1; up_din = 32'h10; sb.push_back(32'h10);
        tick();
        tick();
        up_ack = 1'b1; up_din = 32'h11; sb.push_back(32'h11);
        tick();
        tick();
        chk("t4_level_pre", 32'(level), 32'd2);
        up_ack = 1'b1; up_din = 32'h12; sb.push_back(32'h12);
        dn_req = 1'b1;
        tick();
        dn_req = 1'b0;
        chk("t4_level_same", 32'(level), 32'd2);
        chk("t4_popped", 32'(rx_count), 32'd1);
        chk("t4_oldest", last_rx, 32'h10);
        cons_auto = 1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        chk("t4_drained", 32'(rx_count), 32'd3);
        chk("t4_last", last_rx, 32'h12);

        // T5: forced overflow into a full buffer
        do_reset();
        next_word  = 0;
        prod_limit = 1000;
        prod_en    = 1;
        repeat (20) tick();
        prod_en = 0;
        tick();
        chk("t5_full", 32'(full), 32'd1);
        up_ack = 1'b1; up_din = 32'hDEAD;
        tick();
        chk("t5_err", 32'(err_overflow), 32'd1);
        chk("t5_level", 32'(level), 32'd4);
        repeat (3) tick();
        chk("t5_err_sticky", 32'(err_overflow), 32'd1);
        saw_dead  = 0;
        cons_auto = 1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        repeat (4) tick();
        chk("t5_drain_count", 32'(rx_count), 32'd4);
        chk("t5_no_dead", 32'(saw_dead), 32'd0);
        chk("t5_err_after_drain", 32'(err_overflow), 32'd1);
        do_reset();
        chk("t5_err_cleared", 32'(err_overflow), 32'd0);

        // T6: reset at level 3, then an ack right after reset is captured
        do_reset();
        next_word  = 0;
        prod_limit = 1000;
        prod_en    = 1;
        for (int i = 0; i < 50 && level != LW'(3); i++) tick();
        chk("t6_level3", 32'(level), 32'd3);
        rst     = 1'b1;
        prod_en = 0;
        sb.delete();
        tick();
        chk("t6_level_rst", 32'(level), 32'd0);
        chk("t6_dn_ack_rst", 32'(dn_ack), 32'd0);
        chk("t6_empty_rst", 32'(empty), 32'd1);
        rst    = 1'b0;
        up_ack = 1'b1; up_din = 32'h100; sb.push_back(32'h100);
        tick();
        chk("t6_level_capture", 32'(level), 32'd1);
        rx_count  = 0;
        cons_auto = 1;
        for (int i = 0; i < 20 && rx_count < 1; i++) tick();
        chk("t6_rx_count", 32'(rx_count), 32'd1);
        chk("t6_first_word", last_rx, 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
